// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_add_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fa_1bit.sv
// Combinational 1-bit full adder; the single arithmetic cell that the
// serial controller reuses once per bit position.
module fa_1bit (
   output logic s,
   output logic co,
   input  logic a,
   input  logic b,
   input  logic ci
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder controller. Operands are latched on start and
// fed LSB first through one shared full adder, one bit per cycle, with
// the carry kept in a register. After WIDTH cycles the collected sum and
// carry-out are published together with a one-cycle done pulse.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Upper WIDTH-1 sum bits gathered so far; the newest bit enters at the top.
   logic [WIDTH-2:0] acc;
   logic             c_reg;
   logic [CW-1:0]    cnt;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] acc_next;

   fa_1bit u_fa (
      .s  (fa_s),
      .co (fa_co),
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (c_reg)
   );

   // After this cycle's shift the full WIDTH bits are {new bit, previous bits};
   // on the last cycle this is exactly the finished sum.
   assign acc_next = {fa_s, acc};

   // Sequencer: accept an add in IDLE, shift one bit pair per RUN cycle,
   // publish the result on the last RUN edge, then spend one cycle in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         c_reg <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         co    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  c_reg <= ci;
                  acc   <= '0;
                  cnt   <= '0;
                  sum   <= '0;
                  co    <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               c_reg <= fa_co;
               acc   <= acc_next[WIDTH-1:1];
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  sum   <= acc_next;
                  co    <= fa_co;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a WIDTH=8 instance driven from a
// table of directed vectors plus hand-written multi-cycle sequences, and a
// WIDTH=3 instance checked exhaustively against a+b+ci.
module tb_serial_add_ctrl;

   localparam int W8 = 8;
   localparam int W3 = 3;

   logic clk = 1'b0;

   logic          rst8, start8, ci8, busy8, done8, co8;
   logic [W8-1:0] a8, b8, sum8;

   logic          rst3, start3, ci3, busy3, done3, co3;
   logic [W3-1:0] a3, b3, sum3;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] exp_sum;
      logic       exp_co;
      bit         scramble;
      string      name;
   } vec_t;

   vec_t vecs[8];

   // Free-running clock shared by both instances.
   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W8)) dut8 (
      .clk   (clk),
      .rst   (rst8),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .ci    (ci8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .co    (co8)
   );

   serial_add_ctrl #(.WIDTH(W3)) dut3 (
      .clk   (clk),
      .rst   (rst3),
      .start (start3),
      .a     (a3),
      .b     (b3),
      .ci    (ci3),
      .busy  (busy3),
      .done  (done3),
      .sum   (sum3),
      .co    (co3)
   );

   function automatic vec_t mkVec(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                  input logic [7:0] s, input logic c, input bit scr,
                                  input string name);
      vec_t v;
      v.a        = a;
      v.b        = b;
      v.ci       = ci;
      v.exp_sum  = s;
      v.exp_co   = c;
      v.scramble = scr;
      v.name     = name;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One WIDTH=8 add: start at an edge, observe WIDTH+2 cycles, check timing and result.
   task automatic applyStimulus(input vec_t v);
      int done_k;
      int busy_n;
      int done_n;
      done_k = -1;
      busy_n = 0;
      done_n = 0;
      @(negedge clk);
      a8     = v.a;
      b8     = v.b;
      ci8    = v.ci;
      start8 = 1'b1;
      for (int k = 0; k <= W8 + 1; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start8 = 1'b0;
            checkOutput({v.name, "/sum_cleared"}, 32'(sum8), 32'(0));
         end
         if (busy8) busy_n++;
         if (done8) begin
            done_n++;
            if (done_k < 0) done_k = k;
         end
         if (v.scramble) begin
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            ci8 = 1'($urandom);
         end
      end
      checkOutput({v.name, "/done_cycle"}, 32'(done_k), 32'(W8));
      checkOutput({v.name, "/done_pulses"}, 32'(done_n), 32'(1));
      checkOutput({v.name, "/busy_cycles"}, 32'(busy_n), 32'(W8 + 1));
      checkOutput({v.name, "/sum"}, 32'(sum8), 32'(v.exp_sum));
      checkOutput({v.name, "/co"}, 32'(co8), 32'(v.exp_co));
   endtask

   // One WIDTH=3 add checked against the integer reference a+b+ci.
   task automatic runAdd3(input int av, input int bv, input int cv);
      int done_k;
      int expv;
      done_k = -1;
      expv   = av + bv + cv;
      @(negedge clk);
      a3     = 3'(av);
      b3     = 3'(bv);
      ci3    = 1'(cv);
      start3 = 1'b1;
      for (int k = 0; k <= W3 + 1; k++) begin
         @(negedge clk);
         if (k == 0) start3 = 1'b0;
         if (done3 && done_k < 0) done_k = k;
      end
      checkOutput($sformatf("w3_%0d_%0d_%0d/done_cycle", av, bv, cv), 32'(done_k), 32'(W3));
      checkOutput($sformatf("w3_%0d_%0d_%0d/result", av, bv, cv), 32'({co3, sum3}), 32'(expv));
   endtask

   // Safety net so the run always ends even if the sequencing stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int first_k;
      int second_k;
      int done_n;

      vecs[0] = mkVec(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
      vecs[1] = mkVec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
      vecs[2] = mkVec(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c1");
      vecs[3] = mkVec(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1, "scramble_a5_5a_c1");
      vecs[4] = mkVec(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "add_zero");
      vecs[5] = mkVec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "add_80_80");
      vecs[6] = mkVec(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, "add_7f_00_c1");
      vecs[7] = mkVec(8'h96, 8'h37, 1'b1, 8'hCE, 1'b0, 1'b1, "scramble_96_37_c1");

      rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
      rst3 = 1'b1; start3 = 1'b0; a3 = '0; b3 = '0; ci3 = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset8/busy", 32'(busy8), 32'(0));
      checkOutput("reset8/done", 32'(done8), 32'(0));
      checkOutput("reset8/sum",  32'(sum8),  32'(0));
      checkOutput("reset8/co",   32'(co8),   32'(0));
      checkOutput("reset3/busy", 32'(busy3), 32'(0));
      checkOutput("reset3/sum",  32'({co3, sum3}), 32'(0));
      rst8 = 1'b0;
      rst3 = 1'b0;

      $display("[TB] table-driven vectors, WIDTH=8");
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      $display("[TB] start held high across back-to-back adds");
      first_k  = -1;
      second_k = -1;
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
      for (int k = 0; k <= 2 * W8 + 3; k++) begin
         @(negedge clk);
         if (done8) begin
            if (first_k < 0) first_k = k;
            else if (second_k < 0) second_k = k;
         end
         if (k == W8 + 1) begin
            checkOutput("hold/idle_gap_busy", 32'(busy8), 32'(0));
            checkOutput("hold/sum_held", 32'(sum8), 32'(8'h46));
         end
      end
      start8 = 1'b0;
      checkOutput("hold/first_done", 32'(first_k), 32'(W8));
      checkOutput("hold/second_done", 32'(second_k), 32'(2 * W8 + 2));
      checkOutput("hold/sum", 32'(sum8), 32'(8'h46));
      checkOutput("hold/co", 32'(co8), 32'(0));

      $display("[TB] reset during the 4th RUN cycle");
      @(negedge clk);
      a8 = 8'h33; b8 = 8'h44; ci8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      @(negedge clk);
      checkOutput("midrst/busy", 32'(busy8), 32'(0));
      checkOutput("midrst/done", 32'(done8), 32'(0));
      checkOutput("midrst/sum",  32'(sum8),  32'(0));
      checkOutput("midrst/co",   32'(co8),   32'(0));
      rst8 = 1'b0;
      done_n = 0;
      repeat (W8 + 2) begin
         @(negedge clk);
         if (done8) done_n++;
      end
      checkOutput("midrst/no_done", 32'(done_n), 32'(0));
      applyStimulus(mkVec(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_rst_01_01"));

      $display("[TB] exhaustive WIDTH=3");
      for (int av = 0; av < 8; av++)
         for (int bv = 0; bv < 8; bv++)
            for (int cv = 0; cv < 2; cv++)
               runAdd3(av, bv, cv);

      $display("[TB] reset and start at the same edge");
      @(negedge clk);
      a3 = 3'd5; b3 = 3'd6; ci3 = 1'b1;
      rst3 = 1'b1; start3 = 1'b1;
      @(negedge clk);
      checkOutput("rst_start/busy", 32'(busy3), 32'(0));
      checkOutput("rst_start/result", 32'({co3, sum3}), 32'(0));
      rst3 = 1'b0; start3 = 1'b0;
      @(negedge clk);
      checkOutput("rst_start/still_idle", 32'(busy3), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
